fetch_pc_ctrl: RTL
==================

Name: fetch_pc_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the PC mux select.
- Chooses the next-PC source each cycle: sequential, branch, exception-return (ECP) or trap.
- Runs the single-outstanding AHB instruction-fetch handshake, holding the address through wait states.
- Queues redirects that arrive mid-transfer and flags misaligned targets.
- Sits between the PC mux and the AHB instruction port, ahead of decode.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value loaded by reset.
PC_W, 32, PC/address width (fixed 32; parameterised for lint only).

Ports:
clk_in  input  1  system clock, rising edge
rst_in  input  1  synchronous, active-high reset
ahb_ready_in  input  1  AHB HREADY for the instruction port; high completes the current beat
stall_in  input  1  decode back-pressure; no new beat issued while high
branch_taken_in  input  1  branch/jump redirect request
branch_target_in  input  32  branch target
mret_in  input  1  exception-return redirect request
ecp_in  input  32  exception return PC
trap_taken_in  input  1  trap redirect request
trap_address_in  input  32  trap vector; bits [1:0] forced to 0 internally
pc_src_out  output  2  PC mux select: 00 seq, 01 branch, 10 ecp, 11 trap
pc_out  output  32  current PC register
iaddr_out  output  32  AHB fetch address (word aligned)
fetch_req_out  output  1  AHB NONSEQ request for a beat at iaddr_out
instr_valid_out  output  1  fetched word for instr_pc_out is valid this cycle
instr_pc_out  output  32  PC of the word flagged by instr_valid_out
flush_out  output  1  one-cycle pulse; discard the in-flight word
misaligned_instr_out  output  1  misaligned target detected; level until trap
misaligned_addr_out  output  32  offending target, for mtval

Behaviour:
- States: BOOT, FETCH, WAIT, MISALIGN.
- Reset, synchronous, also mid-transfer:
  - state=BOOT; pc_out = iaddr_out = BOOT_ADDR.
  - pc_src_out=00.
  - fetch_req_out, instr_valid_out, flush_out, misaligned_instr_out = 0.
  - instr_pc_out, misaligned_addr_out = 0.
  - Pending redirect cleared.
- BOOT: lasts one cycle, then FETCH. No request is issued in BOOT.
- FETCH:
  - fetch_req_out = !stall_in.
  - Beat completes when fetch_req_out && ahb_ready_in. Following cycle: instr_valid_out=1 with instr_pc_out = completed address.
  - fetch_req_out && !ahb_ready_in: go to WAIT.
- WAIT:
  - iaddr_out and fetch_req_out held stable.
  - Return to FETCH on the cycle ahb_ready_in=1; this is the completion.
- Next PC at each completion, priority trap > mret > branch > sequential:
  - Sources are the live requests OR-ed with the pending register.
  - pc_src_out reflects the chosen source in that same cycle.
  - Sequential: pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- Redirect in a cycle with no completion: latched into the pending register, holding source and target.
  - A later request of higher priority overwrites it; lower or equal priority is ignored.
  - Pending is cleared at the completion that consumes it.
- Any redirect consumed at a completion:
  - flush_out=1 in the following cycle.
  - instr_valid_out suppressed for that completed word, which was the wrong-path fetch.
- Redirect in the same cycle as BOOT: applied to the first fetch; no flush.
- Misaligned target (branch or ecp with target[1:0] != 0), checked at consumption:
  - State goes to MISALIGN; misaligned_instr_out=1; misaligned_addr_out=target; pc_out unchanged.
  - No requests are issued in MISALIGN.
  - Exit only on trap_taken_in: pc <= trap target, then FETCH.
- Latency: redirect request to first fetch of the new target = 1 cycle when ahb_ready is high.
- stall_in: blocks new beats only. A beat already in WAIT still completes.

Decomposition:
- Shared package fetch_pkg holds:
  - pc_src_e encoding (SEQ=2'b00, BRANCH=2'b01, ECP=2'b10, TRAP=2'b11).
  - fetch_state_e.
  - PC_INC=32'd4.
- Sub-module fetch_redirect_q: single-entry priority pending-redirect register, providing set/overwrite/consume and a valid/src/target output.
- FSM and PC register stay in the top module.

Test Plan:
- Reset release, ready=1, no redirects -> fetch_req_out rises in cycle 2; iaddr_out 0,4,8,...; instr_valid_out one cycle later each beat; pc_src_out=00.
- Ready low 3 cycles at iaddr 32'h10 -> iaddr_out held 32'h10 and fetch_req_out held for 4 cycles; next address 32'h14; no duplicate instr_valid_out.
- branch_taken_in with target 32'h200 during a wait state, then trap_taken_in with trap_address 32'h80 before ready -> after completion pc_src_out=11, next iaddr 32'h80, flush_out one cycle, branch dropped.
- Simultaneous branch (32'h100) and mret (ecp 32'h300) at completion -> pc_src_out=10, iaddr 32'h300, flush_out=1.
- branch target 32'h102 -> misaligned_instr_out=1, misaligned_addr_out=32'h102, no requests; trap_taken_in (32'h40) -> iaddr 32'h40, misaligned cleared.
- rst_in asserted during WAIT with PC 32'h1FFC -> next cycle pc_out=BOOT_ADDR, all outputs at reset values, pending cleared; sequential wrap from 32'hFFFF_FFFC -> 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      SRC_SEQ    = 2'b00,
      SRC_BRANCH = 2'b01,
      SRC_ECP    = 2'b10,
      SRC_TRAP   = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_FETCH,
      ST_WAIT,
      ST_MISALIGN
   } fetch_state_e;

   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_redirect_q.sv
// Single-entry pending-redirect register; a new request only replaces the held one
// when its priority is strictly higher (the source encoding doubles as the priority).
module fetch_redirect_q
   import fetch_pkg::*;
#(
   parameter int PC_W = 32
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [1:0]      set_src,
   input  logic [PC_W-1:0] set_target,
   input  logic            consume,
   output logic            valid,
   output logic [1:0]      src,
   output logic [PC_W-1:0] target
);

   always_ff @(posedge clk) begin
      if (rst || consume) begin
         valid  <= 1'b0;
         src    <= SRC_SEQ;
         target <= '0;
      end else if (set_en && (!valid || (set_src > src))) begin
         valid  <= 1'b1;
         src    <= set_src;
         target <= set_target;
      end
   end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: owns the PC, picks the next-PC source and runs the
// single-outstanding AHB instruction fetch.
module fetch_pc_ctrl
   import fetch_pkg::*;
#(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] BOOT_ADDR = '0
)
(
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            ahb_ready_in,
   input  logic            stall_in,
   input  logic            branch_taken_in,
   input  logic [PC_W-1:0] branch_target_in,
   input  logic            mret_in,
   input  logic [PC_W-1:0] ecp_in,
   input  logic            trap_taken_in,
   input  logic [PC_W-1:0] trap_address_in,
   output logic [1:0]      pc_src_out,
   output logic [PC_W-1:0] pc_out,
   output logic [PC_W-1:0] iaddr_out,
   output logic            fetch_req_out,
   output logic            instr_valid_out,
   output logic [PC_W-1:0] instr_pc_out,
   output logic            flush_out,
   output logic            misaligned_instr_out,
   output logic [PC_W-1:0] misaligned_addr_out
);

   fetch_state_e    state, state_n;
   logic [PC_W-1:0] pc, pc_n;
   logic            instr_valid, instr_valid_n;
   logic [PC_W-1:0] instr_pc, instr_pc_n;
   logic            flush, flush_n;
   logic            misaligned, misaligned_n;
   logic [PC_W-1:0] mis_addr, mis_addr_n;

   logic            fetch_req, complete;
   logic [1:0]      pc_src;
   logic            live_any;
   logic [1:0]      live_src;
   logic [PC_W-1:0] live_target;
   logic            pend_valid;
   logic [1:0]      pend_src;
   logic [PC_W-1:0] pend_target;
   logic            use_pend, redirect, sel_misaligned, q_set, q_consume;
   logic [1:0]      sel_src;
   logic [PC_W-1:0] sel_target;

   always_comb begin
      live_any    = trap_taken_in | mret_in | branch_taken_in;
      live_src    = SRC_SEQ;
      live_target = '0;
      if (trap_taken_in) begin
         live_src    = SRC_TRAP;
         live_target = trap_address_in & ~{{(PC_W-2){1'b0}}, 2'b11};
      end else if (mret_in) begin
         live_src    = SRC_ECP;
         live_target = ecp_in;
      end else if (branch_taken_in) begin
         live_src    = SRC_BRANCH;
         live_target = branch_target_in;
      end
   end

   // An equal-priority live request loses to the held one, matching the queue's ignore rule.
   assign use_pend       = pend_valid && (!live_any || (pend_src >= live_src));
   assign redirect       = live_any || pend_valid;
   assign sel_src        = use_pend ? pend_src : live_src;
   assign sel_target     = use_pend ? pend_target : live_target;
   assign sel_misaligned = redirect && (sel_src != SRC_TRAP) && (sel_target[1:0] != 2'b00);

   assign q_set     = live_any && !complete && ((state == ST_FETCH) || (state == ST_WAIT));
   assign q_consume = complete || (state == ST_BOOT);

   fetch_redirect_q #(.PC_W(PC_W)) u_redirect_q (
      .clk        (clk_in),
      .rst        (rst_in),
      .set_en     (q_set),
      .set_src    (live_src),
      .set_target (live_target),
      .consume    (q_consume),
      .valid      (pend_valid),
      .src        (pend_src),
      .target     (pend_target)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= ST_BOOT;
         pc          <= BOOT_ADDR;
         instr_valid <= 1'b0;
         instr_pc    <= '0;
         flush       <= 1'b0;
         misaligned  <= 1'b0;
         mis_addr    <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         instr_valid <= instr_valid_n;
         instr_pc    <= instr_pc_n;
         flush       <= flush_n;
         misaligned  <= misaligned_n;
         mis_addr    <= mis_addr_n;
      end
   end

   // BOOT and beat completion are the only points where a redirect is consumed.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      fetch_req     = 1'b0;
      complete      = 1'b0;
      pc_src        = SRC_SEQ;
      instr_valid_n = 1'b0;
      instr_pc_n    = instr_pc;
      flush_n       = 1'b0;
      misaligned_n  = misaligned;
      mis_addr_n    = mis_addr;
      unique case (state)
         ST_BOOT: begin
            state_n = ST_FETCH;
            if (redirect) begin
               pc_src = sel_src;
               if (sel_misaligned) begin
                  state_n      = ST_MISALIGN;
                  misaligned_n = 1'b1;
                  mis_addr_n   = sel_target;
               end else begin
                  pc_n = sel_target;
               end
            end
         end
         ST_FETCH, ST_WAIT: begin
            fetch_req = (state == ST_WAIT) || !stall_in;
            complete  = fetch_req && ahb_ready_in;
            if (complete) begin
               state_n       = ST_FETCH;
               instr_pc_n    = pc;
               instr_valid_n = !redirect;
               flush_n       = redirect;
               if (!redirect) begin
                  pc_n = pc + PC_INC[PC_W-1:0];
               end else begin
                  pc_src = sel_src;
                  if (sel_misaligned) begin
                     state_n      = ST_MISALIGN;
                     misaligned_n = 1'b1;
                     mis_addr_n   = sel_target;
                  end else begin
                     pc_n = sel_target;
                  end
               end
            end else if (fetch_req) begin
               state_n = ST_WAIT;
            end
         end
         ST_MISALIGN: begin
            if (trap_taken_in) begin
               state_n      = ST_FETCH;
               pc_n         = live_target;
               pc_src       = SRC_TRAP;
               misaligned_n = 1'b0;
            end
         end
         default: state_n = ST_BOOT;
      endcase
   end

   assign pc_src_out           = pc_src;
   assign pc_out               = pc;
   assign iaddr_out            = pc;
   assign fetch_req_out        = fetch_req;
   assign instr_valid_out      = instr_valid;
   assign instr_pc_out         = instr_pc;
   assign flush_out            = flush;
   assign misaligned_instr_out = misaligned;
   assign misaligned_addr_out  = mis_addr;

endmodule
